logcap_sequencer: RTL
=====================

// Module: logcap_sequencer
// PURPOSE
// - Capture sequencer behind the logcap command/register port: decodes the 8-bit command/strobe, runs arm->trigger->post-count->done.
// - Drives the sample-buffer write port and owns the readback pointer.
// - Sits between the C&C hub (command, regOut0..4, status) and the dual-port capture RAM.
// PARAMETERS
// - ADDR_W    10  capture RAM address width; depth = 2**ADDR_W
// - SAMPLE_W   8  probe sample width
// PORTS
// - clk             in   1         system clock (100 MHz)
// - reset           in   1         async, active-low reset
// - command_strobe  in   1         1-cycle command valid
// - command         in   8         opcode, sampled when command_strobe=1
// - cfg_trig_value  in   8         trigger compare value (regOut0)
// - cfg_trig_mask   in   8         1 = bit participates in compare (regOut1)
// - cfg_post_lo     in   8         post-trigger sample count [7:0] (regOut2)
// - cfg_post_hi     in   8         post-trigger sample count [15:8] (regOut3)
// - sample_in       in   SAMPLE_W  probe data
// - sample_valid    in   1         sample tick; sample_in valid this cycle
// - mem_we          out  1         RAM write enable (registered)
// - mem_waddr       out  ADDR_W    RAM write address (registered)
// - mem_wdata       out  SAMPLE_W  RAM write data (registered)
// - mem_raddr       out  ADDR_W    RAM readback address
// - trig_addr       out  ADDR_W    RAM address holding the trigger sample
// - status          out  8         {3'b0, wrapped, trig_seen, done, state[1:0]}
// - done_pulse      out  1         1-cycle pulse on entry to DONE
// BEHAVIOUR
// - reset=0 (async): state=IDLE(0); wptr, mem_raddr, trig_addr, post counter = 0; mem_we=0; mem_waddr=0;
//   mem_wdata=0; wrapped/trig_seen=0; done_pulse=0; status=8'h00.
// - Opcodes: 01 ARM, 02 ABORT, 03 FORCE_TRIG, 04 REWIND, 05 READ_NEXT; any other value is ignored (no state change).
// - States: IDLE=0, ARMED=1, TRIGGERED=2, DONE=3. status[2] done = (state==DONE).
// - ARM (any state): wptr=0, wrapped=0, trig_seen=0 -> ARMED. The sample_valid in the ARM cycle is dropped.
// - ABORT (any state): -> IDLE next cycle; no further writes; wptr/trig_addr retained. A sample in the ABORT cycle is dropped.
// - ARMED: each sample_valid writes sample_in @wptr, wptr++ (mod depth); wptr wrap 2**ADDR_W-1 -> 0 sets wrapped.
//   match = ((sample_in ^ cfg_trig_value) & cfg_trig_mask) == 0. Mask 0 triggers on the first valid sample.
//   On match: the sample is written, trig_addr=wptr (its address), trig_seen=1, -> TRIGGERED.
//   cnt = min({cfg_post_hi,cfg_post_lo}, 2**ADDR_W-1); config is sampled at this cycle only.
// - FORCE_TRIG in ARMED: same as match. With sample_valid=1 that sample is the trigger sample;
//   else trig_addr=wptr (next slot). FORCE_TRIG ignored in other states.
// - TRIGGERED: cnt==0 -> DONE next cycle, no write. Else each sample_valid writes, wptr++, cnt--;
//   the write taking cnt to 0 -> DONE. Exactly cnt post-trigger samples are written.
// - DONE entry: done_pulse=1 for 1 cycle; mem_raddr = oldest = wrapped ? wptr : 0. No writes in DONE/IDLE.
// - REWIND: mem_raddr = oldest. READ_NEXT: mem_raddr++ mod depth. Both honoured in IDLE and DONE only; ignored otherwise.
// - Write port latency: sample_valid at cycle N -> mem_we/mem_waddr/mem_wdata valid at N+1; mem_we=0 when no write.
// - status is registered and reflects state one cycle after the transition.
// CONFIGURATION
// - LOGCAP_TRIG_EDGE_EN defined: trigger also requires that the previous valid sample did NOT match.
//   The previous-sample register is cleared to "matching" on ARM, so the first sample after ARM cannot trigger. FORCE_TRIG unaffected.
// - LOGCAP_TRIG_EDGE_EN undefined: level trigger; any matching valid sample triggers.
// TESTING
// - Reset mid-TRIGGERED: drop reset -> status=00, mem_we=0, mem_raddr=0 immediately (async).
// - ADDR_W=4, mask=FF, value=A5, post=3:
//   ARM, samples 00..04, A5, 10,11,12,13 -> trig_addr=5, mem writes @0..8, DONE after 12, done_pulse once,
//   status=0x0F, 13 not written, mem_raddr=0.
// - ADDR_W=4, mask=FF, value=FF, post=2: ARM, 20 non-matching samples then FF,1,2 -> wrapped=1.
//   trig_addr=4, mem_raddr=7 on DONE; 16x READ_NEXT wraps back to 7.
// - post=0, mask=00: ARM, one sample -> written @0, trig_addr=0, DONE next cycle, no further mem_we.
// - FORCE_TRIG with no sample_valid after 3 samples (ADDR_W=4, post=1) -> trig_addr=3.
//   ABORT during TRIGGERED -> IDLE, status=0x08; opcode 0x7E in IDLE -> no change.
// - LOGCAP_TRIG_EDGE_EN, mask=01, value=01: ARM, samples 01,01,00,01 -> triggers on the 4th sample (trig_addr=3).
//   Undefined -> triggers on the 1st (trig_addr=0).

Source files
------------

// File: rtl/logcap_sequencer.sv
// Capture sequencer for logcap: decodes commands, runs arm->trigger->post-count->done,
// drives the capture RAM write port and owns the readback pointer. Optional macro: LOGCAP_TRIG_EDGE_EN.
module logcap_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                command_strobe,
  input  logic [7:0]          command,
  input  logic [7:0]          cfg_trig_value,
  input  logic [7:0]          cfg_trig_mask,
  input  logic [7:0]          cfg_post_lo,
  input  logic [7:0]          cfg_post_hi,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0]   mem_raddr,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic [7:0]          status,
  output logic                done_pulse
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRIGGERED = 2'd2, DONE = 2'd3} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  // Post-trigger count can never exceed what the buffer holds besides the trigger sample.
  function automatic logic [ADDR_W-1:0] sat_post(input logic [15:0] p);
    if (32'(p) > 32'(ADDR_MAX)) return ADDR_MAX;
    else                        return p[ADDR_W-1:0];
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     wptr_q, wptr_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]     raddr_q, raddr_d;
  logic [ADDR_W-1:0]     trig_addr_q, trig_addr_d;
  logic                  wrapped_q, wrapped_d;
  logic                  trig_seen_q, trig_seen_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [SAMPLE_W-1:0]   wdata_q, wdata_d;
  logic                  done_pulse_q, done_pulse_d;
  logic [7:0]            status_q, status_d;

  logic cmd_arm, cmd_abort, cmd_force, cmd_rewind, cmd_next;
  logic raw_match, trig_hit;

  assign cmd_arm    = command_strobe && (command == 8'h01);
  assign cmd_abort  = command_strobe && (command == 8'h02);
  assign cmd_force  = command_strobe && (command == 8'h03);
  assign cmd_rewind = command_strobe && (command == 8'h04);
  assign cmd_next   = command_strobe && (command == 8'h05);

  assign raw_match = ((sample_in ^ SAMPLE_W'(cfg_trig_value)) & SAMPLE_W'(cfg_trig_mask)) == '0;

`ifdef LOGCAP_TRIG_EDGE_EN
  // Remembers whether the previous valid sample matched; starts as "matching" after ARM.
  logic prev_match_q, prev_match_d;

  always_comb begin
    prev_match_d = prev_match_q;
    if (cmd_arm)
      prev_match_d = 1'b1;
    else if (!cmd_abort && state_q == ARMED && sample_valid)
      prev_match_d = raw_match;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_match_q <= 1'b0;
    else        prev_match_q <= prev_match_d;
  end

  assign trig_hit = raw_match && !prev_match_q;
`else
  assign trig_hit = raw_match;
`endif

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    cnt_d        = cnt_q;
    raddr_d      = raddr_q;
    trig_addr_d  = trig_addr_q;
    wrapped_d    = wrapped_q;
    trig_seen_d  = trig_seen_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    done_pulse_d = 1'b0;

    if (cmd_abort) begin
      state_d = IDLE;
    end else if (cmd_arm) begin
      wptr_d      = '0;
      wrapped_d   = 1'b0;
      trig_seen_d = 1'b0;
      state_d     = ARMED;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (cmd_rewind)    raddr_d = wrapped_q ? wptr_q : '0;
          else if (cmd_next) raddr_d = raddr_q + ADDR_W'(1);
        end
        ARMED: begin
          if (sample_valid) begin
            we_d    = 1'b1;
            waddr_d = wptr_q;
            wdata_d = sample_in;
            wptr_d  = wptr_q + ADDR_W'(1);
            if (wptr_q == ADDR_MAX) wrapped_d = 1'b1;
          end
          // Forced trigger without a sample points at the slot the next sample will fill.
          if ((sample_valid && trig_hit) || cmd_force) begin
            trig_addr_d = wptr_q;
            trig_seen_d = 1'b1;
            cnt_d       = sat_post({cfg_post_hi, cfg_post_lo});
            state_d     = TRIGGERED;
          end
        end
        TRIGGERED: begin
          if (cnt_q == '0) begin
            state_d = DONE;
          end else if (sample_valid) begin
            we_d    = 1'b1;
            waddr_d = wptr_q;
            wdata_d = sample_in;
            wptr_d  = wptr_q + ADDR_W'(1);
            if (wptr_q == ADDR_MAX) wrapped_d = 1'b1;
            cnt_d   = cnt_q - ADDR_W'(1);
            if (cnt_q == ADDR_W'(1)) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d == DONE && state_q != DONE) begin
      done_pulse_d = 1'b1;
      raddr_d      = wrapped_d ? wptr_d : '0;
    end
  end

  assign status_d = {3'b000, wrapped_q, trig_seen_q, (state_q == DONE), state_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      cnt_q        <= '0;
      raddr_q      <= '0;
      trig_addr_q  <= '0;
      wrapped_q    <= 1'b0;
      trig_seen_q  <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      done_pulse_q <= 1'b0;
      status_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      raddr_q      <= raddr_d;
      trig_addr_q  <= trig_addr_d;
      wrapped_q    <= wrapped_d;
      trig_seen_q  <= trig_seen_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      done_pulse_q <= done_pulse_d;
      status_q     <= status_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign mem_raddr  = raddr_q;
  assign trig_addr  = trig_addr_q;
  assign status     = status_q;
  assign done_pulse = done_pulse_q;

endmodule
